pixel_stream_source: RTL and testbench
======================================

# pixel_stream_source

Frame-buffered pixel transmitter that drives the serial `in_valid`/`in_data` input of the CNN classifier top. A host loads one IMG_W×IMG_H 8-bit image into an internal buffer, pulses `start`, and the block streams the pixels in raster order as a valid-qualified byte stream. It then waits for the classifier's `class_valid`/`class_out` return, captures the result, and flags a timeout if no result arrives.

## Interface
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- DATA_W, 8, pixel width
- ROW_GAP, 0, idle cycles inserted after each row except the last (0..255)
- TIMEOUT_CYCLES, 200000, maximum WAIT_RESULT cycles before error (≥1)
- NPIX = IMG_W*IMG_H (local); AW = clog2(NPIX) (local, 10 by default)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  host buffer write strobe
- wr_addr  in  AW  pixel index (row*IMG_W+col)
- wr_data  in  DATA_W  pixel value
- start  in  1  launch one frame (single-cycle pulse)
- out_valid  out  1  pixel valid, to classifier `in_valid`
- out_data  out  DATA_W  pixel, to classifier `in_data`
- class_in  in  4  classifier `class_out`
- class_in_valid  in  1  classifier `class_valid`
- busy  out  1  frame in progress
- result_class  out  4  captured class
- result_valid  out  1  one-cycle pulse on capture
- timeout_err  out  1  sticky: no result within TIMEOUT_CYCLES
- frame_cnt  out  16  completed (classified) frames, wraps at 65535→0

## Operation
- Buffer: NPIX×DATA_W RAM, not reset; contents survive reset. Writes accepted only when busy=0; wr_en with busy=1 ignored. wr_addr ≥ NPIX ignored.
- FSM states IDLE, STREAM, GAP, WAIT_RESULT.
- IDLE: start=1 → STREAM, rd_addr=0, col=0, row=0, timeout_err cleared, busy=1. start while busy ignored.
- STREAM: one pixel read per cycle; col increments; at col=IMG_W-1: if last row → WAIT_RESULT; else if ROW_GAP>0 → GAP; else continue next row.
- GAP: counts ROW_GAP cycles with no read, then back to STREAM.
- WAIT_RESULT: wait counter from 0. class_in_valid=1 → result_class←class_in, result_valid pulse, frame_cnt+1, → IDLE. Counter reaching TIMEOUT_CYCLES-1 without result → timeout_err=1, no result_valid, frame_cnt unchanged, → IDLE. Result and timeout in same cycle: result wins.
- class_in_valid outside WAIT_RESULT (including during STREAM) ignored.
- result_class holds until next capture.

## Timing
- Reset values: out_valid 0, out_data 0, busy 0, result_class 0, result_valid 0, timeout_err 0, frame_cnt 0; FSM IDLE.
- RAM read is registered: pixel at address a, read in cycle c, appears on out_data/out_valid in cycle c+1.
- start sampled high at edge t → busy=1 after edge t; first pixel (addr 0) valid after edge t+2.
- ROW_GAP=0: out_valid high for exactly NPIX consecutive cycles. Otherwise out_valid low for exactly ROW_GAP cycles between rows; total stream window NPIX+(IMG_H-1)*ROW_GAP cycles.
- out_data holds last pixel when out_valid=0 (not required zero).
- WAIT_RESULT entered the cycle after last pixel read; class_in_valid may coincide with the final out_valid cycle and is captured.
- result_valid, frame_cnt update, busy deassert all visible after the same edge.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously); no partial result; next start streams from address 0.

## Test plan
- Write pixel i = i mod 256 for i=0..783, start → 784 consecutive out_valid cycles, data 0..255,0..255,0..255,0..15; first valid 2 cycles after start; busy high throughout.
- ROW_GAP=2, same image → 28 valid, 2 idle, repeated; 838-cycle window, 54 idle cycles, last pixel 15.
- After stream, class_in=7, class_in_valid 100 cycles later → result_valid one cycle, result_class=7, frame_cnt=1, busy=0; second frame → frame_cnt=2.
- TIMEOUT_CYCLES=50, no class_in_valid → timeout_err=1 50 cycles after WAIT_RESULT entry, busy=0, result_valid never high; next start clears timeout_err.
- During STREAM: start pulse, wr_en to addr 5 with 0xAA, class_in_valid → no restart, buffer unchanged (next frame pixel 5 = 5), no result capture.
- Assert rst_n=0 at pixel 300 → out_valid/busy 0 immediately; after release start → full 784-pixel stream from pixel 0 with original data.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Frame-buffered pixel transmitter: streams a host-loaded image in raster order,
// then waits for the classifier's result with a timeout watchdog.
module pixel_stream_source #(
   parameter int IMG_W          = 28,
   parameter int IMG_H          = 28,
   parameter int DATA_W         = 8,
   parameter int ROW_GAP        = 0,
   parameter int TIMEOUT_CYCLES = 200000,
   localparam int NPIX          = IMG_W * IMG_H,
   localparam int AW            = (NPIX > 1) ? $clog2(NPIX) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [3:0]        class_in,
   input  logic              class_in_valid,
   output logic              busy,
   output logic [3:0]        result_class,
   output logic              result_valid,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt
);

   // state       | meaning
   // S_IDLE      | waiting for start, buffer writable
   // S_STREAM    | one buffer read per cycle, raster order
   // S_GAP       | idle cycles between rows
   // S_WAIT      | waiting for classifier result or timeout

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_WAIT} state_t;

   state_t            state;
   logic [AW-1:0]     rd_addr;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [7:0]        gap_cnt;
   logic [WW-1:0]     wait_cnt;
   logic              rd_vld;
   logic              rd_fire;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] mem [NPIX];

   assign rd_fire = (state == S_STREAM);

   // Buffer is intentionally not reset so an image survives a mid-frame reset.
   always_ff @(posedge clk) begin
      if (wr_en && !busy && (32'(wr_addr) < 32'(NPIX)))
         mem[wr_addr] <= wr_data;
      if (rd_fire)
         rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         rd_addr      <= '0;
         col          <= '0;
         row          <= '0;
         gap_cnt      <= '0;
         wait_cnt     <= '0;
         rd_vld       <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         busy         <= 1'b0;
         result_class <= '0;
         result_valid <= 1'b0;
         timeout_err  <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         result_valid <= 1'b0;
         rd_vld       <= rd_fire;
         out_valid    <= rd_vld;
         if (rd_vld)
            out_data <= rd_data;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_STREAM;
                  rd_addr     <= '0;
                  col         <= '0;
                  row         <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            S_STREAM: begin
               rd_addr <= rd_addr + AW'(1);
               if (col == CW'(IMG_W - 1)) begin
                  col <= '0;
                  if (row == RW'(IMG_H - 1)) begin
                     state    <= S_WAIT;
                     wait_cnt <= WW'(TIMEOUT_CYCLES - 1);
                  end else begin
                     row <= row + RW'(1);
                     if (ROW_GAP > 0) begin
                        state   <= S_GAP;
                        gap_cnt <= 8'(ROW_GAP - 1);
                     end
                  end
               end else begin
                  col <= col + CW'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == 8'd0)
                  state <= S_STREAM;
               else
                  gap_cnt <= gap_cnt - 8'd1;
            end
            S_WAIT: begin
               // A result arriving on the terminal count still counts as a result.
               if (class_in_valid) begin
                  result_class <= class_in;
                  result_valid <= 1'b1;
                  frame_cnt    <= frame_cnt + 16'd1;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end else if (wait_cnt == '0) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - WW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source: dut0 has default timing, dut1 has
// ROW_GAP=2 and a 50-cycle timeout.
module tb_pixel_stream_source;

   logic       clk = 1'b0;
   logic       rst_n [2];
   logic       wr_en [2];
   logic [9:0] wr_addr [2];
   logic [7:0] wr_data [2];
   logic       start [2];
   logic       out_valid [2];
   logic [7:0] out_data [2];
   logic [3:0] class_in [2];
   logic       class_in_valid [2];
   logic       busy [2];
   logic [3:0] result_class [2];
   logic       result_valid [2];
   logic       timeout_err [2];
   logic [15:0] frame_cnt [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pixel_stream_source u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
      .wr_data(wr_data[0]), .start(start[0]), .out_valid(out_valid[0]),
      .out_data(out_data[0]), .class_in(class_in[0]),
      .class_in_valid(class_in_valid[0]), .busy(busy[0]),
      .result_class(result_class[0]), .result_valid(result_valid[0]),
      .timeout_err(timeout_err[0]), .frame_cnt(frame_cnt[0])
   );

   pixel_stream_source #(.ROW_GAP(2), .TIMEOUT_CYCLES(50)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
      .wr_data(wr_data[1]), .start(start[1]), .out_valid(out_valid[1]),
      .out_data(out_data[1]), .class_in(class_in[1]),
      .class_in_valid(class_in_valid[1]), .busy(busy[1]),
      .result_class(result_class[1]), .result_valid(result_valid[1]),
      .timeout_err(timeout_err[1]), .frame_cnt(frame_cnt[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int k);
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
   endtask

   // Launch a dut0 frame and follow it to the end of out_valid.
   // disturb: poke start/wr_en/class_in_valid early in the stream.
   // cap_last: present class 3 on the final out_valid cycle.
   task automatic run_frame0(input string tag, input bit disturb, input bit cap_last);
      int n = 0, data_errs = 0, busy_errs = 0, rv_hits = 0;
      pulse_start(0);
      check({tag, "_busy_on"}, busy[0], 1);
      tick();
      check({tag, "_no_valid_early"}, out_valid[0], 0);
      tick();
      check({tag, "_first_valid"}, out_valid[0], 1);
      while (out_valid[0] && n < 2000) begin
         if (out_data[0] !== 8'(n % 256)) data_errs++;
         if (!busy[0]) busy_errs++;
         if (result_valid[0]) rv_hits++;
         start[0] = 1'b0; wr_en[0] = 1'b0; class_in_valid[0] = 1'b0;
         if (disturb && n == 3) begin
            start[0] = 1'b1; wr_en[0] = 1'b1; wr_addr[0] = 10'd5; wr_data[0] = 8'hAA;
            class_in[0] = 4'd9; class_in_valid[0] = 1'b1;
         end
         if (cap_last && n == 783) begin
            class_in[0] = 4'd3; class_in_valid[0] = 1'b1;
         end
         n++;
         tick();
      end
      start[0] = 1'b0; wr_en[0] = 1'b0;
      check({tag, "_valid_count"}, n, 784);
      check({tag, "_data_errs"}, data_errs, 0);
      check({tag, "_busy_errs"}, busy_errs, 0);
      check({tag, "_early_result"}, rv_hits, 0);
      check({tag, "_data_hold"}, out_data[0], 15);
   endtask

   initial begin
      int n, pat_errs, data_errs, p, rv_hits;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
         start[k] = 1'b0; class_in[k] = '0; class_in_valid[k] = 1'b0;
      end
      tick(); tick();
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      tick();
      check("rst_out_valid", out_valid[0], 0);
      check("rst_out_data", out_data[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_result_class", result_class[0], 0);
      check("rst_frame_cnt", frame_cnt[0], 0);
      check("rst_timeout", timeout_err[1], 0);

      for (int i = 0; i < 784; i++) begin
         for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b1; wr_addr[k] = 10'(i); wr_data[k] = 8'(i % 256);
         end
         tick();
      end
      wr_en[0] = 1'b0; wr_en[1] = 1'b0;

      // frame 1: result arrives 100 cycles after the stream
      run_frame0("f1", 1'b0, 1'b0);
      repeat (99) tick();
      class_in[0] = 4'd7; class_in_valid[0] = 1'b1;
      tick();
      class_in_valid[0] = 1'b0;
      check("f1_result_valid", result_valid[0], 1);
      check("f1_result_class", result_class[0], 7);
      check("f1_frame_cnt", frame_cnt[0], 1);
      check("f1_busy_off", busy[0], 0);
      tick();
      check("f1_result_pulse", result_valid[0], 0);
      check("f1_class_hold", result_class[0], 7);

      // frame 2: ignored pokes while busy, result on the final out_valid cycle
      run_frame0("f2", 1'b1, 1'b1);
      class_in_valid[0] = 1'b0;
      check("f2_result_valid", result_valid[0], 1);
      check("f2_result_class", result_class[0], 3);
      check("f2_frame_cnt", frame_cnt[0], 2);
      check("f2_busy_off", busy[0], 0);

      // frame 3: reset mid-stream, then a clean frame from the preserved buffer
      pulse_start(0);
      tick(); tick();
      n = 0;
      while (out_valid[0] && n < 300) begin
         n++;
         tick();
      end
      check("rst_mid_pixel", n, 300);
      rst_n[0] = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid[0], 0);
      check("rst_mid_busy", busy[0], 0);
      check("rst_mid_frame_cnt", frame_cnt[0], 0);
      tick();
      rst_n[0] = 1'b1;
      tick();
      run_frame0("f3", 1'b0, 1'b0);
      class_in[0] = 4'd2; class_in_valid[0] = 1'b1;
      tick();
      class_in_valid[0] = 1'b0;
      check("f3_frame_cnt", frame_cnt[0], 1);

      // dut1: row gaps then timeout
      pulse_start(1);
      check("g_busy_on", busy[1], 1);
      tick(); tick();
      pat_errs = 0; data_errs = 0; p = 0; rv_hits = 0;
      for (int i = 0; i < 838; i++) begin
         if (out_valid[1] !== ((i % 30) < 28)) pat_errs++;
         if (out_valid[1]) begin
            if (out_data[1] !== 8'(p % 256)) data_errs++;
            p++;
         end
         if (result_valid[1]) rv_hits++;
         if (i != 837) tick();
      end
      check("g_pattern_errs", pat_errs, 0);
      check("g_data_errs", data_errs, 0);
      check("g_pixels", p, 784);
      check("g_last_pixel", out_data[1], 15);
      tick();
      check("g_window_end", out_valid[1], 0);
      for (int i = 0; i < 47; i++) begin
         if (result_valid[1]) rv_hits++;
         tick();
      end
      check("to_not_yet", timeout_err[1], 0);
      check("to_busy_still", busy[1], 1);
      tick();
      if (result_valid[1]) rv_hits++;
      check("to_err_set", timeout_err[1], 1);
      check("to_busy_off", busy[1], 0);
      check("to_frame_cnt", frame_cnt[1], 0);
      check("to_no_result", rv_hits, 0);
      tick();
      check("to_sticky", timeout_err[1], 1);
      pulse_start(1);
      check("to_cleared", timeout_err[1], 0);
      check("to_restart_busy", busy[1], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
